// File: rtl/retire_unit.sv
// ----------------------------------------------------------------------------
// retire_unit
// In-order commit stage. Consumes the completed ROB head and retires it:
// architectural register write, store commit through the data-memory store
// port, mispredict squash/redirect, and halt. Pops the ROB via retire_ack.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   head_*                ROB head entry (valid/complete, dest, value, addr,
//                         store/halt/mispredict flags, branch target)
//   mem_grant             memory accepts the pending store this cycle
//   retire_ack            pop the ROB head this cycle (combinational)
//   rf_we/rf_idx/rf_data  architectural register write (combinational)
//   mem_req/addr/data     registered store request
//   squash, redirect_pc   registered pipeline flush and fetch redirect
//   halted                sticky halt indication
//   retire_count          retired-instruction counter, wraps
// ----------------------------------------------------------------------------
module retire_unit #(
    parameter int unsigned DEST_W        = 5,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              head_valid,
    input  logic [DEST_W-1:0] head_dest,
    input  logic [XLEN-1:0]   head_value,
    input  logic [XLEN-1:0]   head_addr,
    input  logic              head_is_store,
    input  logic              head_is_halt,
    input  logic              head_mispredict,
    input  logic [XLEN-1:0]   head_target,

    input  logic              mem_grant,

    output logic              retire_ack,
    output logic              rf_we,
    output logic [DEST_W-1:0] rf_idx,
    output logic [XLEN-1:0]   rf_data,

    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_data,

    output logic              squash,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count
);

    // Squash counter must hold SQUASH_CYCLES itself.
    localparam int unsigned SQ_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        SQUASH     = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t          state_q;
    logic [SQ_W-1:0] sq_cnt_q;

    // Head decode, priority halt > mispredict > store > normal.
    logic run_valid;
    logic dec_halt;
    logic dec_misp;
    logic dec_store;
    logic dec_normal;
    logic store_done;

    always_comb begin
        run_valid  = (state_q == RUN) && head_valid && !reset;
        dec_halt   = run_valid && head_is_halt;
        dec_misp   = run_valid && !head_is_halt && head_mispredict;
        dec_store  = run_valid && !head_is_halt && !head_mispredict && head_is_store;
        dec_normal = run_valid && !head_is_halt && !head_mispredict && !head_is_store;
        // A store retires in the cycle memory accepts it; head inputs are ignored here.
        store_done = (state_q == STORE_WAIT) && mem_grant && !reset;
    end

    // Combinational pop and RF write port.
    always_comb begin
        retire_ack = dec_halt || dec_misp || dec_normal || store_done;
        rf_we      = (dec_misp || dec_normal) && (head_dest != '0);
        rf_idx     = head_dest;
        rf_data    = head_value;
    end

    // Commit FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            sq_cnt_q     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            squash       <= 1'b0;
            redirect_pc  <= '0;
            halted       <= 1'b0;
            retire_count <= '0;
        end else begin
            if (retire_ack) begin
                retire_count <= retire_count + CNT_W'(1);
            end

            case (state_q)
                RUN: begin
                    if (dec_halt) begin
                        halted  <= 1'b1;
                        state_q <= HALTED;
                    end else if (dec_misp) begin
                        redirect_pc <= head_target;
                        squash      <= 1'b1;
                        sq_cnt_q    <= SQ_W'(SQUASH_CYCLES);
                        state_q     <= SQUASH;
                    end else if (dec_store) begin
                        mem_addr <= head_addr;
                        mem_data <= head_value;
                        mem_req  <= 1'b1;
                        state_q  <= STORE_WAIT;
                    end
                end

                STORE_WAIT: begin
                    if (mem_grant) begin
                        mem_req <= 1'b0;
                        state_q <= RUN;
                    end
                end

                SQUASH: begin
                    // Counter was loaded with SQUASH_CYCLES; last squash cycle sees 1.
                    sq_cnt_q <= sq_cnt_q - SQ_W'(1);
                    if (sq_cnt_q <= SQ_W'(1)) begin
                        squash  <= 1'b0;
                        state_q <= RUN;
                    end
                end

                HALTED: begin
                    state_q <= HALTED;
                end

                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/retire_unit.md
# retire_unit

In-order commit stage that consumes the completed head entry of the ROB and retires it: architectural register write, store commit to memory, branch-mispredict squash and redirect, and halt. It is the reader of the ROB's head/retire interface and issues the pop (`retire_ack`) that advances the ROB head pointer. It sits between the ROB, the architectural register file, the data-memory store port and the fetch/redirect logic.

## Interface
- `DEST_W`, 5: architectural register index width; index 0 means no destination.
- `XLEN`, 32: data/address width.
- `CNT_W`, 32: retired-instruction counter width.
- `SQUASH_CYCLES`, 2: cycles `squash` is held high after a mispredict retires; minimum 1.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `head_valid`  in  1  ROB head entry is valid and complete.
- `head_dest`  in  DEST_W  architectural destination of the head.
- `head_value`  in  XLEN  result value; store data for stores.
- `head_addr`  in  XLEN  store address (stores only).
- `head_is_store`  in  1  head is a store.
- `head_is_halt`  in  1  head is a halt instruction.
- `head_mispredict`  in  1  head is a resolved, mispredicted branch.
- `head_target`  in  XLEN  correct branch target.
- `mem_grant`  in  1  memory accepts the pending store this cycle.
- `retire_ack`  out  1  pop head this cycle (combinational).
- `rf_we`, `rf_idx`, `rf_data`  out  1/DEST_W/XLEN  architectural register write (combinational, sampled by the RF on the next edge).
- `mem_req`, `mem_addr`, `mem_data`  out  1/XLEN/XLEN  registered store request.
- `squash`  out  1  registered flush of all in-flight state.
- `redirect_pc`  out  XLEN  registered fetch redirect, valid while `squash`.
- `halted`  out  1  sticky halt indication.
- `retire_count`  out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W.

## Operation
- FSM states: RUN, STORE_WAIT, SQUASH, HALTED. Reset state is RUN.
- RUN, `head_valid`=0: no action.
- RUN, `head_valid`=1. Flags are decoded with priority halt > mispredict > store > normal:
  - Normal: `retire_ack`=1. If `head_dest`!=0, `rf_we`=1 with `rf_idx`=`head_dest` and `rf_data`=`head_value`. Stay in RUN.
  - Store: no ack. Latch `head_addr` and `head_value` into `mem_addr` and `mem_data`, set `mem_req`, and go to STORE_WAIT. No RF write.
  - Mispredict: ack, plus RF write if `head_dest`!=0 (link register). Latch `redirect_pc`=`head_target`, set `squash`, load the squash counter with SQUASH_CYCLES, and go to SQUASH.
  - Halt: ack, no RF write. Set `halted` and go to HALTED.
- STORE_WAIT: hold `mem_req`, `mem_addr` and `mem_data` stable.
  - On `mem_grant`=1: `retire_ack`=1 in the same cycle, `mem_req` clears at the next edge, return to RUN.
  - Head inputs are ignored while waiting.
- SQUASH: `squash`=1 for exactly SQUASH_CYCLES cycles. No acks and no RF writes. The counter decrements, and at zero the FSM clears `squash` and returns to RUN.
- HALTED: absorbing until reset. No acks, no writes, no memory requests.
- `retire_count` increments by 1 on every edge where `retire_ack`=1.
- `mem_grant` outside STORE_WAIT is ignored.

## Timing
- Reset values: state RUN; `mem_req`=0, `mem_addr`=0, `mem_data`=0, `squash`=0, `redirect_pc`=0, `halted`=0, `retire_count`=0. Combinational outputs (`retire_ack`, `rf_we`) evaluate to 0 while reset is high.
- Normal retire: ack and RF write are in the same cycle the head is presented. Throughput is 1 instruction per cycle. The ROB presents the new head after the edge.
- Store: `mem_req` rises on the edge after the store is seen at head. Minimum latency from store-at-head to ack is 2 cycles (grant in the first request cycle).
- Mispredict: ack in cycle T. `squash` and `redirect_pc` are valid from edge T+1 through T+SQUASH_CYCLES. The first new retire is possible in cycle T+SQUASH_CYCLES+1.
- Reset asserted mid-STORE_WAIT or mid-SQUASH drops `mem_req` and `squash` asynchronously. No ack is issued for the pending store.
- Counter overflow wraps to 0 silently.

## Test plan
- Reset, then 4 consecutive normal heads with dest 1..4 and values 0x10..0x40 -> 4 acks in 4 cycles; RF writes r1=0x10 … r4=0x40; `retire_count`=4.
- Head with dest=0 and value 0xDEAD -> ack=1, `rf_we`=0, count +1.
- Store with addr 0x1000 and data 0xAB, `mem_grant` held low 3 cycles then pulsed -> `mem_req` high 4 cycles with stable addr/data; single ack in the grant cycle; no RF write.
- Mispredict with dest 1 and target 0x2040, SQUASH_CYCLES=2, valid heads following -> ack and r1 write; `squash`=1 and `redirect_pc`=0x2040 for exactly 2 cycles; no acks during that time; the next head acks one cycle later.
- Halt at head followed by valid normal heads -> one ack; `halted`=1 persists; no further acks or writes for 10 cycles.
- Reset asserted in the 2nd STORE_WAIT cycle -> `mem_req`=0 immediately; `retire_count`=0; state RUN; no ack.
